remote_cmd_rx: RTL and testbench

Robot-side endpoint of the remote command link. It consumes the byte stream from the UART receiver, reassembles each 16-bit command sent high byte first then low byte, and presents it with a ready flag. It also transmits one response byte per request through the UART transmitter. It sits between the UART byte interface and the command-processing logic.

---
 rtl/remote_cmd_rx_pkg.sv | 16 +
 rtl/remote_cmd_rx_if.sv | 35 +++
 rtl/remote_cmd_rx_byte_timer.sv | 36 +++
 rtl/remote_cmd_rx.sv | 143 ++++++++++++++
 tb/tb_remote_cmd_rx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/remote_cmd_rx_pkg.sv
// Shared types for the remote command link: receive/transmit FSM states
// and byte/command widths used by both the link endpoint and command logic.
package remote_cmd_pkg;

    typedef enum logic {RX_HIGH, RX_LOW}  rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    localparam int BYTE_W = 8;
    localparam int CMD_W  = 16;

    // Counter width for an inter-byte timeout of 'cycles' clocks (never 0).
    function automatic int timer_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/remote_cmd_rx_if.sv
// UART byte side, command side and response side of the remote command link.
interface remote_cmd_rx_if;
    import remote_cmd_pkg::*;

    logic                rx_rdy;
    logic [BYTE_W-1:0]   rx_data;
    logic                clr_rx_rdy;
    logic                trmt;
    logic [BYTE_W-1:0]   tx_data;
    logic                tx_done;
    logic [CMD_W-1:0]    cmd;
    logic                cmd_rdy;
    logic                clr_cmd_rdy;
    logic                send_resp;
    logic [BYTE_W-1:0]   resp;
    logic                tx_busy;
    logic                resp_sent;
    logic                frame_err;
    logic                overrun;

    // Link endpoint view.
    modport slave (
        input  rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp,
        output clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, tx_busy,
               resp_sent, frame_err, overrun
    );

    // UART / command-processing view.
    modport master (
        output rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp,
        input  clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, tx_busy,
               resp_sent, frame_err, overrun
    );

endinterface

// File: rtl/remote_cmd_rx_byte_timer.sv
// Saturating up-counter with clear, enable and terminal-count flag.
module byte_timer #(
    parameter int WIDTH    = 16,
    parameter int TERMINAL = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] TC_V = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Next count: clear dominates, then count up and hold at terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != TC_V))
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == TC_V);

endmodule

// File: rtl/remote_cmd_rx.sv
// Robot-side endpoint of the remote command link: assembles 16-bit commands
// from high/low UART bytes with an inter-byte timeout, and sends one
// response byte per request through the UART transmitter.
module remote_cmd_rx
    import remote_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic               clk,
    input  logic               rst,
    remote_cmd_rx_if.slave     bus
);

    localparam int TMR_W = timer_width(TIMEOUT_CYCLES);

    rx_state_t           rx_state_q, rx_state_d;
    tx_state_t           tx_state_q, tx_state_d;
    logic [BYTE_W-1:0]   high_q, high_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic                cmd_rdy_q, cmd_rdy_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                trmt_q, trmt_d;
    logic                resp_sent_q, resp_sent_d;
    logic                tmr_clr, tmr_en, tmr_tc;

    byte_timer #(
        .WIDTH    (TMR_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // Receive FSM next state: a byte arriving on the timeout cycle still wins.
    always_comb begin
        rx_state_d  = rx_state_q;
        high_d      = high_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q && !bus.clr_cmd_rdy;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        unique case (rx_state_q)
            RX_HIGH: begin
                tmr_clr = 1'b1;
                if (bus.rx_rdy) begin
                    high_d     = bus.rx_data;
                    rx_state_d = RX_LOW;
                end
            end
            RX_LOW: begin
                if (bus.rx_rdy) begin
                    cmd_d      = {high_q, bus.rx_data};
                    cmd_rdy_d  = 1'b1;
                    overrun_d  = cmd_rdy_q;
                    rx_state_d = RX_HIGH;
                end else if (tmr_tc) begin
                    frame_err_d = 1'b1;
                    high_d      = '0;
                    rx_state_d  = RX_HIGH;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: rx_state_d = RX_HIGH;
        endcase
    end

    // Receive state and command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_HIGH;
            high_q      <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            high_q      <= high_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Transmit FSM next state: requests while busy are dropped.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_data_d  = bus.resp;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (bus.tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Transmit state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign bus.clr_rx_rdy = bus.rx_rdy && !rst;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.trmt       = trmt_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_busy    = (tx_state_q == TX_BUSY);
    assign bus.resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_remote_cmd_rx.sv
// Directed bench for remote_cmd_rx with TIMEOUT_CYCLES = 16.
module tb_remote_cmd_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    remote_cmd_rx_if bus ();

    remote_cmd_rx #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one cycle; checks clr_rx_rdy follows rx_rdy.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        #1;
        chk("clr_rx_rdy_hi", {15'd0, bus.clr_rx_rdy}, 16'd1);
        tick();
        bus.rx_rdy = 1'b0;
        #1;
        chk("clr_rx_rdy_lo", {15'd0, bus.clr_rx_rdy}, 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd"},       bus.cmd, 16'h0000);
        chk({tag, "_cmd_rdy"},   {15'd0, bus.cmd_rdy}, 16'd0);
        chk({tag, "_clr_rx"},    {15'd0, bus.clr_rx_rdy}, 16'd0);
        chk({tag, "_trmt"},      {15'd0, bus.trmt}, 16'd0);
        chk({tag, "_tx_data"},   {8'd0, bus.tx_data}, 16'h0000);
        chk({tag, "_tx_busy"},   {15'd0, bus.tx_busy}, 16'd0);
        chk({tag, "_resp_sent"}, {15'd0, bus.resp_sent}, 16'd0);
        chk({tag, "_frame_err"}, {15'd0, bus.frame_err}, 16'd0);
        chk({tag, "_overrun"},   {15'd0, bus.overrun}, 16'd0);
    endtask

    initial begin
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.tx_done     = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.resp        = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst0");
        rst = 1'b0;
        tick();

        // Basic command assembly 0xA5, 0x3C.
        send_byte(8'hA5);
        chk("t1_rdy_after_high", {15'd0, bus.cmd_rdy}, 16'd0);
        send_byte(8'h3C);
        chk("t1_cmd", bus.cmd, 16'hA53C);
        chk("t1_cmd_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
        chk("t1_overrun", {15'd0, bus.overrun}, 16'd0);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("t1_rdy_cleared", {15'd0, bus.cmd_rdy}, 16'd0);
        chk("t1_cmd_held", bus.cmd, 16'hA53C);

        // Inter-byte timeout after high byte 0x12.
        send_byte(8'h12);
        for (int i = 0; i < 15; i++) tick();
        chk("t2_no_err_early", {15'd0, bus.frame_err}, 16'd0);
        tick();
        chk("t2_frame_err", {15'd0, bus.frame_err}, 16'd1);
        tick();
        chk("t2_frame_err_pulse", {15'd0, bus.frame_err}, 16'd0);
        send_byte(8'h34);
        send_byte(8'h56);
        chk("t2_cmd", bus.cmd, 16'h3456);
        chk("t2_cmd_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;

        // Low byte on the exact timeout cycle is accepted.
        send_byte(8'h77);
        for (int i = 0; i < 15; i++) tick();
        send_byte(8'h88);
        chk("t6_cmd", bus.cmd, 16'h7788);
        chk("t6_no_err", {15'd0, bus.frame_err}, 16'd0);
        tick();
        chk("t6_no_err_late", {15'd0, bus.frame_err}, 16'd0);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;

        // Overrun: two commands without acknowledge.
        send_byte(8'h11);
        send_byte(8'h11);
        chk("t3_first_no_ovr", {15'd0, bus.overrun}, 16'd0);
        send_byte(8'h22);
        send_byte(8'h22);
        chk("t3_overrun", {15'd0, bus.overrun}, 16'd1);
        chk("t3_cmd", bus.cmd, 16'h2222);
        chk("t3_cmd_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
        tick();
        chk("t3_overrun_pulse", {15'd0, bus.overrun}, 16'd0);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("t3_cleared", {15'd0, bus.cmd_rdy}, 16'd0);
        send_byte(8'h33);
        bus.clr_cmd_rdy = 1'b1;
        send_byte(8'h44);
        bus.clr_cmd_rdy = 1'b0;
        chk("t3_set_wins", {15'd0, bus.cmd_rdy}, 16'd1);
        chk("t3_cmd2", bus.cmd, 16'h3344);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;

        // Response transmission; request while busy is dropped.
        bus.resp      = 8'hA5;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        chk("t4_trmt", {15'd0, bus.trmt}, 16'd1);
        chk("t4_tx_data", {8'd0, bus.tx_data}, 16'h00A5);
        chk("t4_busy", {15'd0, bus.tx_busy}, 16'd1);
        tick();
        chk("t4_trmt_pulse", {15'd0, bus.trmt}, 16'd0);
        bus.resp      = 8'h5A;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        chk("t4_ignored_trmt", {15'd0, bus.trmt}, 16'd0);
        chk("t4_ignored_data", {8'd0, bus.tx_data}, 16'h00A5);
        chk("t4_still_busy", {15'd0, bus.tx_busy}, 16'd1);
        chk("t4_no_sent_yet", {15'd0, bus.resp_sent}, 16'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("t4_resp_sent", {15'd0, bus.resp_sent}, 16'd1);
        chk("t4_idle", {15'd0, bus.tx_busy}, 16'd0);
        tick();
        chk("t4_resp_sent_pulse", {15'd0, bus.resp_sent}, 16'd0);
        chk("t4_no_retx", {15'd0, bus.trmt}, 16'd0);

        // Reset mid-command and mid-transmit.
        send_byte(8'hFF);
        bus.resp      = 8'h3C;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        chk("t5_busy_before", {15'd0, bus.tx_busy}, 16'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("t5_rst");
        rst = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("t5_done_ignored", {15'd0, bus.resp_sent}, 16'd0);
        chk("t5_still_idle", {15'd0, bus.tx_busy}, 16'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        chk("t5_cmd", bus.cmd, 16'h0102);
        chk("t5_cmd_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
